// File: rtl/instruction_cache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package instruction_cache_pkg;

  localparam int RAM_ADDR_WIDTH = 18;
  localparam int INST_WIDTH     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read, one synchronous write, reset clears valid bits.
module icache_line_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = RAM_ADDR_WIDTH - 2 - INDEX_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [INST_WIDTH-1:0]  rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [INST_WIDTH-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache with IDLE/MISS FSM.
// Optional ICACHE_PERF_EN adds hit_count/miss_count outputs.
// Handshake: fetch_en is held by IF until the one-cycle inst_ready pulse;
// icache_query_en is held until the one-cycle icache_block_en pulse.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_signal,
  input  logic                  fetch_en,
  input  logic [31:0]           fetch_addr,
  output logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic                  icache_query_en,
  output logic [31:0]           head_addr,
  input  logic                  icache_block_en,
  input  logic [INST_WIDTH-1:0] icache_block_data,
`ifdef ICACHE_PERF_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  output icache_state_t         state_dbg
);

  localparam int TAG_WIDTH = RAM_ADDR_WIDTH - 2 - INDEX_WIDTH;

  icache_state_t          state_q, state_d;
  logic                   ready_d;
  logic [INST_WIDTH-1:0]  data_d;
  logic                   query_d;
  logic [31:0]            head_d;
  logic [INDEX_WIDTH-1:0] miss_index_q, miss_index_d;
  logic [TAG_WIDTH-1:0]   miss_tag_q, miss_tag_d;
  logic                   wr_req;
  logic                   hit_inc;
  logic                   miss_inc;

  logic [INDEX_WIDTH-1:0] fetch_index;
  logic [TAG_WIDTH-1:0]   fetch_tag;
  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic [INST_WIDTH-1:0]  rd_data;
  logic                   unused_addr_bits;

  assign fetch_index      = fetch_addr[INDEX_WIDTH+1:2];
  assign fetch_tag        = fetch_addr[RAM_ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_addr_bits = ^fetch_addr[1:0];
  assign state_dbg        = state_q;

  icache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_lines (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (fetch_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_req & rdy_in),
    .wr_index (miss_index_q),
    .wr_tag   (miss_tag_q),
    .wr_data  (icache_block_data)
  );

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    data_d       = inst_data;
    query_d      = icache_query_en;
    head_d       = head_addr;
    miss_index_d = miss_index_q;
    miss_tag_d   = miss_tag_q;
    wr_req       = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    if (flush_signal) begin
      // Flush wins over a coincident block return; the fill is dropped.
      state_d = IDLE;
      query_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en && !inst_ready) begin
            if (rd_valid && (rd_tag == fetch_tag)) begin
              data_d  = rd_data;
              ready_d = 1'b1;
              hit_inc = 1'b1;
            end else begin
              miss_index_d = fetch_index;
              miss_tag_d   = fetch_tag;
              head_d       = {fetch_addr[31:2], 2'b00};
              query_d      = 1'b1;
              state_d      = MISS;
              miss_inc     = 1'b1;
            end
          end
        end
        MISS: begin
          if (icache_block_en) begin
            wr_req  = 1'b1;
            data_d  = icache_block_data;
            ready_d = 1'b1;
            query_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      inst_ready      <= 1'b0;
      inst_data       <= '0;
      icache_query_en <= 1'b0;
      head_addr       <= '0;
      miss_index_q    <= '0;
      miss_tag_q      <= '0;
    end else if (rdy_in) begin
      state_q         <= state_d;
      inst_ready      <= ready_d;
      inst_data       <= data_d;
      icache_query_en <= query_d;
      head_addr       <= head_d;
      miss_index_q    <= miss_index_d;
      miss_tag_q      <= miss_tag_d;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy_in) begin
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache (INDEX_WIDTH=6).
module tb_instruction_cache;
  import instruction_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_signal, fetch_en;
  logic [31:0] fetch_addr;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        icache_query_en;
  logic [31:0] head_addr;
  logic        icache_block_en;
  logic [31:0] icache_block_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif
  icache_state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_cache #(.INDEX_WIDTH(6)) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .flush_signal      (flush_signal),
    .fetch_en          (fetch_en),
    .fetch_addr        (fetch_addr),
    .inst_ready        (inst_ready),
    .inst_data         (inst_data),
    .icache_query_en   (icache_query_en),
    .head_addr         (head_addr),
    .icache_block_en   (icache_block_en),
    .icache_block_data (icache_block_data),
`ifdef ICACHE_PERF_EN
    .hit_count         (hit_count),
    .miss_count        (miss_count),
`endif
    .state_dbg         (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss: request seen one cycle after fetch, memory answers 6 cycles later.
  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] word);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    step();
    check("miss_query", {31'd0, icache_query_en}, 32'd1);
    check("miss_head", head_addr, {addr[31:2], 2'b00});
    check("miss_noready", {31'd0, inst_ready}, 32'd0);
    repeat (6) step();
    check("miss_hold", {31'd0, icache_query_en}, 32'd1);
    exp_q.push_back(word);
    icache_block_en   = 1'b1;
    icache_block_data = word;
    step();
    icache_block_en   = 1'b0;
    icache_block_data = 32'hDEAD_BEEF;
    fetch_en          = 1'b0;
    check("fill_ready", {31'd0, inst_ready}, 32'd1);
    check("fill_data", inst_data, exp_q.pop_front());
    check("fill_query_low", {31'd0, icache_query_en}, 32'd0);
    step();
    check("post_fill_query", {31'd0, icache_query_en}, 32'd0);
    check("post_fill_ready", {31'd0, inst_ready}, 32'd0);
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] word);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    exp_q.push_back(word);
    step();
    fetch_en = 1'b0;
    check("hit_ready", {31'd0, inst_ready}, 32'd1);
    check("hit_data", inst_data, exp_q.pop_front());
    check("hit_noquery", {31'd0, icache_query_en}, 32'd0);
    step();
    check("hit_pulse", {31'd0, inst_ready}, 32'd0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) step();
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_signal = 1'b0; fetch_en = 1'b0;
    fetch_addr = '0; icache_block_en = 1'b0; icache_block_data = '0;
    do_reset();
    check("rst_ready", {31'd0, inst_ready}, 32'd0);
    check("rst_query", {31'd0, icache_query_en}, 32'd0);
    check("rst_head", head_addr, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);

    // Cold miss then hit.
    fetch_miss(32'h0000_1004, 32'h0051_0093);
    fetch_hit(32'h0000_1004, 32'h0051_0093);

    // fetch_en held high: lookup is skipped in the inst_ready cycle.
    fetch_en = 1'b1; fetch_addr = 32'h0000_1004;
    step(); check("tput_1", {31'd0, inst_ready}, 32'd1);
    step(); check("tput_gap", {31'd0, inst_ready}, 32'd0);
    step(); check("tput_2", {31'd0, inst_ready}, 32'd1);
    fetch_en = 1'b0;
    step();

    // Conflict: same index 1, tags 0x10 and 0x11; ignored low address bits.
    fetch_miss(32'h0000_1107, 32'h0000_0013);
    fetch_hit(32'h0000_1104, 32'h0000_0013);
    fetch_miss(32'h0000_1004, 32'h0051_0093);

    // Flush mid-miss with coincident block return.
    fetch_en = 1'b1; fetch_addr = 32'h0000_2008;
    step();
    check("fl_query", {31'd0, icache_query_en}, 32'd1);
    step();
    fetch_en = 1'b0; flush_signal = 1'b1;
    icache_block_en = 1'b1; icache_block_data = 32'h1111_1111;
    step();
    flush_signal = 1'b0; icache_block_en = 1'b0;
    check("fl_query_low", {31'd0, icache_query_en}, 32'd0);
    check("fl_noready", {31'd0, inst_ready}, 32'd0);
    check("fl_state", {31'd0, state_dbg}, 32'd0);
    step();
    check("fl_noready2", {31'd0, inst_ready}, 32'd0);
    fetch_miss(32'h0000_2008, 32'h2222_2222);
    fetch_hit(32'h0000_1004, 32'h0051_0093);

    // rdy_in stall during MISS; a block pulse while frozen is ignored.
    fetch_en = 1'b1; fetch_addr = 32'h0000_3000;
    step();
    check("st_query", {31'd0, icache_query_en}, 32'd1);
    rdy_in = 1'b0;
    icache_block_en = 1'b1; icache_block_data = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      step();
      icache_block_en = 1'b0;
      check("st_frozen_query", {31'd0, icache_query_en}, 32'd1);
      check("st_frozen_ready", {31'd0, inst_ready}, 32'd0);
      check("st_frozen_head", head_addr, 32'h0000_3000);
    end
    rdy_in = 1'b1;
    repeat (2) step();
    check("st_resume_query", {31'd0, icache_query_en}, 32'd1);
    icache_block_en = 1'b1; icache_block_data = 32'h4444_4444;
    step();
    icache_block_en = 1'b0; fetch_en = 1'b0;
    check("st_ready", {31'd0, inst_ready}, 32'd1);
    check("st_data", inst_data, 32'h4444_4444);
    step();
    fetch_hit(32'h0000_3000, 32'h4444_4444);

    // Reset invalidates lines and counters.
    do_reset();
    check("rst2_ready", {31'd0, inst_ready}, 32'd0);
    fetch_miss(32'h0000_1004, 32'h0051_0093);
`ifdef ICACHE_PERF_EN
    check("perf_miss", miss_count, 32'd1);
    check("perf_hit", hit_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's ICache port. It serves 32-bit instruction fetches from an internal line array on a hit. On a miss it issues a single 4-byte block request to the memory controller, fills the line, and returns the word. Line contents survive pipeline flushes; only reset invalidates them.

## Interface
- `INDEX_WIDTH`, default 6: line index bits (2^INDEX_WIDTH lines); legal range 2–10.
- `clk_in`  in  1  single clock; all logic on posedge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global enable; low freezes all state and outputs.
- `flush_signal`  in  1  pipeline flush; aborts the outstanding fetch.
- `fetch_en`  in  1  fetch request; held high by IF until `inst_ready`.
- `fetch_addr`  in  32  fetch PC; stable while `fetch_en` is high; bits [1:0] ignored.
- `inst_ready`  out  1  one-cycle pulse; `inst_data` is valid.
- `inst_data`  out  32  fetched instruction word.
- `icache_query_en`  out  1  block request to the memory controller.
- `head_addr`  out  32  block address, {fetch_addr[31:2], 2'b00}.
- `icache_block_en`  in  1  block returned (one-cycle pulse).
- `icache_block_data`  in  32  returned block, little-endian.

## Operation
- Address split over the 18-bit RAM space:
  - index = addr[INDEX_WIDTH+1:2]
  - tag = addr[17:INDEX_WIDTH+2], width 16−INDEX_WIDTH
  - addr[31:18] are not stored.
- Per line storage: valid bit, tag, 32-bit data.
- States: IDLE, MISS.
- **IDLE**, when `fetch_en && !inst_ready`:
  - Hit (valid and tag match): `inst_data` ← line data, `inst_ready` ← 1; stay in IDLE.
  - Miss: latch index and tag, `head_addr` ← aligned address, `icache_query_en` ← 1; go to MISS.
- IDLE gating: `fetch_en` is ignored in the cycle `inst_ready` is high. This lets IF advance the PC before the next lookup.
- **MISS**: hold `icache_query_en` and `head_addr` until `icache_block_en`. On `icache_block_en`:
  - Write the line (valid ← 1, latched tag, block data).
  - `inst_data` ← `icache_block_data`, `inst_ready` ← 1.
  - `icache_query_en` ← 0; go to IDLE.
- `inst_ready` is cleared every cycle it is not being set.
- Conflict: a fill overwrites whatever line is at the index; no write-back is needed because the cache is read-only.
- **Flush**, when `rdy_in` and `flush_signal`:
  - State ← IDLE, `icache_query_en` ← 0, `inst_ready` ← 0.
  - A coincident `icache_block_en` is discarded and nothing is written.
  - Valid bits are retained.
  - Flush takes priority over all other events.
- **`rdy_in` low**: no state change, and any incoming `icache_block_en` is ignored. The memory controller is frozen by the same signal.
- **Reset**:
  - All valid bits ← 0; state IDLE.
  - `inst_ready`, `inst_data`, `icache_query_en`, `head_addr` ← 0.
  - Data and tag arrays need no reset.

## Timing
- Hit latency: `inst_ready` on the edge after `fetch_en` is sampled.
- Maximum throughput: one hit every 2 cycles.
- Miss latency: 1 cycle to raise `icache_query_en`, plus the memory controller latency (6 cycles after it samples the request), plus 0 cycles for data, which is returned on the same edge that fills the line.
- `icache_query_en` is low in the cycle after `icache_block_en`. This matches the memory controller's one-cycle confirm gap, so no duplicate request is issued.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ICACHE_PERF_EN`:
  - Defined: adds outputs `hit_count` and `miss_count`, each out, 32 bits, wrapping. A hit increments on the IDLE hit decision; a miss increments on the IDLE→MISS transition. Both are reset to 0 by `rst_in` and are not cleared by flush.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package:
  - state encoding (IDLE, MISS)
  - `RAM_ADDR_WIDTH` = 18
  - `INST_WIDTH` = 32
- Sub-module `icache_line_array`: valid/tag/data storage.
  - Combinational read port (index → valid, tag, data).
  - One synchronous write port (en, index, tag, data).
  - Synchronous clear of all valid bits on reset.
- The top level holds the FSM, the latched miss address, the output registers and the perf counters.

## Test plan
- **Cold miss**: reset, then fetch 0x0000_1004 with memory word 0x0051_0093.
  - Expect `icache_query_en` with `head_addr`=0x1004 one cycle later.
  - After `icache_block_en`, `inst_ready` with `inst_data`=0x0051_0093.
  - `icache_query_en` low the following cycle.
- **Hit**: re-fetch 0x1004. Expect `inst_ready` the next cycle with 0x0051_0093 and no `icache_query_en`.
- **Conflict (INDEX_WIDTH=6)**:
  - Fetch 0x1004, then 0x1104 (same index, different tag): second fetch misses.
  - Re-fetch 0x1004: misses again.
- **Flush mid-miss**:
  - Assert `flush_signal` while in MISS, with `icache_block_en` in the same cycle.
  - Expect `icache_query_en` 0, no `inst_ready`, and the line not filled (a later fetch of the same address misses).
- **rdy_in stall**: drop `rdy_in` for 3 cycles during MISS. Expect outputs frozen; the request completes normally after resume.
- **Reset clears**: fill 0x1004, pulse `rst_in`, fetch 0x1004. Expect a miss; with `ICACHE_PERF_EN`, expect `miss_count`=1 and `hit_count`=0.
